usb_fifo_writer: RTL and testbench

USB_FIFO_WRITER -- requirements
Module: usb_fifo_writer

---
 rtl/usb_daq_pkg.sv | 15 +
 rtl/usb_fifo_writer_if.sv | 22 ++
 rtl/usb_skid2.sv | 42 ++++
 rtl/usb_fifo_writer.sv | 124 ++++++++++++
 tb/tb_usb_fifo_writer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_daq_pkg.sv
// Shared constants and FSM encoding for the USB DAQ FX2 writer path.
// Holds the default buffer length, EP6 FIFO address and RAM address width.
package usb_daq_pkg;

    localparam int ADDR_W = 11;
    localparam int BUF_LEN_DEF = 2048;
    localparam logic [1:0] EP6_ADDR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/usb_fifo_writer_if.sv
// RAM read port plus FX2 slave-FIFO pins of the writer.
// master = writer side, slave = RAM/FX2 environment side.
interface usb_fifo_writer_if;

    logic [usb_daq_pkg::ADDR_W-1:0] usbdadd;
    logic [7:0] usbdata;
    logic full_n;
    logic [7:0] fd;
    logic slwr_n;
    logic [1:0] fifoadr;

    modport master (
        output usbdadd, fd, slwr_n, fifoadr,
        input  usbdata, full_n
    );

    modport slave (
        input  usbdadd, fd, slwr_n, fifoadr,
        output usbdata, full_n
    );

endinterface

// File: rtl/usb_skid2.sv
// Two-entry byte skid buffer; head_o is valid whenever count_o != 0.
module usb_skid2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] head_o,
    output logic [1:0] count_o
);

    logic [7:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d, wpos;

    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        wpos = cnt_q - {1'b0, pop_i};
        if (pop_i) e0_d = e1_q;
        if (push_i) begin
            if (wpos == 2'd0) e0_d = din_i;
            else              e1_d = din_i;
        end
        cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= 8'h00;
            e1_q  <= 8'h00;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = e0_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/usb_fifo_writer.sv
// Drains one ping-pong buffer half into the FX2 slave FIFO per send_go edge.
// Define FX2_OVERRUN_CNT_EN to add the saturating overrun_cnt port.
module usb_fifo_writer
    import usb_daq_pkg::*;
#(
    parameter int         BUF_LEN = BUF_LEN_DEF,
    parameter logic [1:0] EP_ADDR = EP6_ADDR
) (
    input  logic usbdataclk,
    input  logic rst,
    input  logic send_go,
    output logic busy,
    output logic done,
    usb_fifo_writer_if.master bus
`ifdef FX2_OVERRUN_CNT_EN
    , output logic [7:0] overrun_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BUF_LEN - 1);

    state_e state_q, state_d;
    logic go_q, arm_q, go_rise;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic all_q, all_d, pend_q;
    logic issue, pop;
    logic [1:0] cnt;
    logic [7:0] head;
    logic [2:0] occ;

    // arm_q blocks a level already high when reset releases
    assign go_rise = send_go & ~go_q & arm_q;
    assign pop     = (cnt != 2'd0) & bus.full_n;
    assign occ     = {1'b0, cnt} + {2'b0, pend_q} - {2'b0, pop};

    always_ff @(posedge usbdataclk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (go_rise) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_DRAIN;
            ST_DRAIN: if (done) state_d = go_rise ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // occ<=1 leaves room for the read issued now even if nothing pops next
    always_comb begin
        issue = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            ST_IDLE:  ;
            ST_FETCH: issue = 1'b1;
            ST_DRAIN: begin
                issue = ~all_q & (occ <= 3'd1);
                done  = all_q & ~pend_q & (cnt == 2'd1) & pop;
            end
            default:  ;
        endcase
        busy         = (state_q != ST_IDLE);
        bus.usbdadd  = issue ? addr_q : '0;
        bus.slwr_n   = (cnt == 2'd0);
        bus.fd       = head;
        bus.fifoadr  = EP_ADDR;
    end

    always_comb begin
        addr_d = addr_q;
        all_d  = all_q;
        if (state_q == ST_FETCH) all_d = 1'b0;
        if (issue) begin
            if (addr_q == LAST) begin
                addr_d = '0;
                all_d  = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge usbdataclk or posedge rst) begin
        if (rst) begin
            go_q   <= 1'b0;
            arm_q  <= 1'b0;
            addr_q <= '0;
            all_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            go_q   <= send_go;
            arm_q  <= arm_q | ~send_go;
            addr_q <= addr_d;
            all_q  <= all_d;
            pend_q <= issue;
        end
    end

    usb_skid2 u_skid (
        .clk     (usbdataclk),
        .rst     (rst),
        .push_i  (pend_q),
        .pop_i   (pop),
        .din_i   (bus.usbdata),
        .head_o  (head),
        .count_o (cnt)
    );

`ifdef FX2_OVERRUN_CNT_EN
    logic [7:0] ovr_q;

    always_ff @(posedge usbdataclk or posedge rst) begin
        if (rst)
            ovr_q <= 8'h00;
        else if (go_rise & busy & ~done & (ovr_q != 8'hFF))
            ovr_q <= ovr_q + 8'h01;
    end

    assign overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_usb_fifo_writer.sv
// Directed bench: 2048-byte instance plus a BUF_LEN=4 instance, RAM returns addr[7:0].
// Honours FX2_OVERRUN_CNT_EN for the overrun_cnt port.
module tb_usb_fifo_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, send_go, send_go2;
    logic busy, done, busy2, done2;
`ifdef FX2_OVERRUN_CNT_EN
    logic [7:0] ovr, ovr2;
`endif

    usb_fifo_writer_if bus ();
    usb_fifo_writer_if sbus ();

    usb_fifo_writer dut (
        .usbdataclk (clk),
        .rst        (rst),
        .send_go    (send_go),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
`ifdef FX2_OVERRUN_CNT_EN
        , .overrun_cnt (ovr)
`endif
    );

    usb_fifo_writer #(.BUF_LEN(4)) dut_s (
        .usbdataclk (clk),
        .rst        (rst),
        .send_go    (send_go2),
        .busy       (busy2),
        .done       (done2),
        .bus        (sbus)
`ifdef FX2_OVERRUN_CNT_EN
        , .overrun_cnt (ovr2)
`endif
    );

    always @(posedge clk) bus.usbdata <= bus.usbdadd[7:0];
    always @(posedge clk) sbus.usbdata <= sbus.usbdadd[7:0];

    int checks, errors;
    int nbytes, mbase, ndone, nlast;
    int sn, sdone, slast;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n, input int maxc);
        int k = 0;
        while ((nbytes - mbase) < n && k < maxc) begin
            tick();
            k++;
        end
        check("wait_bytes", nbytes - mbase, n);
    endtask

    task automatic wait_done(input int target, input int maxc);
        int k = 0;
        while (ndone < target && k < maxc) begin
            tick();
            k++;
        end
        check("wait_done", ndone, target);
    endtask

    task automatic kick();
        send_go = 1'b1;
        tick();
        send_go = 1'b0;
    endtask

    initial begin
        int d0, l0, n0;
        checks = 0; errors = 0;
        nbytes = 0; mbase = 0; ndone = 0; nlast = 0;
        sn = 0; sdone = 0; slast = 0;
        rst = 1'b1;
        send_go = 1'b0;
        send_go2 = 1'b0;
        bus.full_n = 1'b1;
        sbus.full_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!bus.slwr_n && bus.full_n) begin
                    check("byte", 32'(bus.fd), (nbytes - mbase) & 255);
                    nbytes++;
                end
                if (done) ndone++;
                if (bus.usbdadd == 11'd2047) nlast++;
                if (!sbus.slwr_n && sbus.full_n) begin
                    check("sbyte", 32'(sbus.fd), sn & 255);
                    sn++;
                end
                if (done2) sdone++;
                if (sbus.usbdadd == 11'd3) slast++;
            end
        join_none

        #2;
        check("rst_slwr", 32'(bus.slwr_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(bus.usbdadd), 0);
        check("rst_fd", 32'(bus.fd), 0);
        check("fifoadr", 32'(bus.fifoadr), 2);
        check("s_fifoadr", 32'(sbus.fifoadr), 2);
`ifdef FX2_OVERRUN_CNT_EN
        check("rst_ovr", 32'(ovr), 0);
        check("rst_ovr2", 32'(ovr2), 0);
`endif
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // single buffer + latency
        mbase = nbytes; d0 = ndone; l0 = nlast;
        send_go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_busy", 32'(busy), 1);
        check("lat_c1", 32'(bus.slwr_n), 1);
        @(negedge clk);
        check("lat_c2", 32'(bus.slwr_n), 1);
        @(negedge clk);
        check("lat_c3", 32'(bus.slwr_n), 0);
        check("first_fd", 32'(bus.fd), 0);
        tick();
        send_go = 1'b0;
        wait_done(d0 + 1, 2600);
        check("t1_bytes", nbytes - mbase, 2048);
        check("t1_last", nlast - l0, 1);
        repeat (3) tick();
        check("t1_idle", 32'(busy), 0);
        check("t1_done_once", ndone - d0, 1);

        // backpressure at byte 100
        mbase = nbytes; d0 = ndone;
        kick();
        wait_bytes(100, 200);
        bus.full_n = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("bp_fd", 32'(bus.fd), 100);
            check("bp_slwr", 32'(bus.slwr_n), 0);
            tick();
        end
        bus.full_n = 1'b1;
        wait_done(d0 + 1, 2600);
        check("bp_bytes", nbytes - mbase, 2048);

        // overrun at byte 500
        mbase = nbytes; d0 = ndone;
        kick();
        wait_bytes(500, 700);
        kick();
        check("ovr_busy", 32'(busy), 1);
        wait_done(d0 + 1, 2600);
        check("ovr_bytes", nbytes - mbase, 2048);
        repeat (5) tick();
        check("ovr_norestart", 32'(busy), 0);
`ifdef FX2_OVERRUN_CNT_EN
        check("ovr_cnt", 32'(ovr), 1);
`endif

        // back-to-back: edge on the done clock
        mbase = nbytes; d0 = ndone;
        kick();
        wait_bytes(2047, 2600);
        send_go = 1'b1;
        @(negedge clk);
        check("b2b_done", 32'(done), 1);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_c1", 32'(bus.slwr_n), 1);
        @(negedge clk);
        check("b2b_c2", 32'(bus.slwr_n), 1);
        @(negedge clk);
        check("b2b_c3", 32'(bus.slwr_n), 0);
        tick();
        send_go = 1'b0;
        wait_done(d0 + 2, 2600);
        check("b2b_bytes", nbytes - mbase, 4096);
`ifdef FX2_OVERRUN_CNT_EN
        check("b2b_ovr", 32'(ovr), 1);
`endif

        // reset at byte 1000
        mbase = nbytes; d0 = ndone;
        kick();
        wait_bytes(1000, 1200);
        rst = 1'b1;
        #1;
        check("mrst_slwr", 32'(bus.slwr_n), 1);
        check("mrst_addr", 32'(bus.usbdadd), 0);
        check("mrst_busy", 32'(busy), 0);
        send_go = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n0 = nbytes;
        repeat (10) tick();
        check("mrst_noedge", 32'(busy), 0);
        check("mrst_nowrite", nbytes - n0, 0);
        send_go = 1'b0;
        tick();
        mbase = nbytes;
        kick();
        wait_done(d0 + 1, 2600);
        check("mrst_bytes", nbytes - mbase, 2048);

        // small buffer with toggling full_n
        send_go2 = 1'b1;
        tick();
        send_go2 = 1'b0;
        repeat (40) begin
            sbus.full_n = ~sbus.full_n;
            tick();
        end
        sbus.full_n = 1'b1;
        repeat (3) tick();
        check("s_bytes", sn, 4);
        check("s_last", slast, 1);
        check("s_done", sdone, 1);
        check("s_idle", 32'(busy2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
